// File: rtl/vector_pkg.sv
`default_nettype none
// ============================================================================
// vector_pkg : Q8.24 fixed-point vector types and scheduler state encoding
// Rev 1.0
// ============================================================================
package vector_pkg;

  // Q8.24 signed fixed point; adds wrap on overflow.
  typedef logic signed [31:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  localparam fp MAX_DIST_DEFAULT = 32'sh6400_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } sched_state_t;

  function automatic vec3 vec3_add(input vec3 a, input vec3 b);
    vec3 r;
    r.x = a.x + b.x;
    r.y = a.y + b.y;
    r.z = a.z + b.z;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ray_dir_gen.sv
`default_nettype none
// ============================================================================
// ray_dir_gen : raster pixel counters and incremental ray direction accumulator
// Rev 1.0
// ============================================================================
module ray_dir_gen
  import vector_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  vec3         base_i,
  input  vec3         dx_i,
  input  vec3         dy_i,
  input  logic        advance_i,
  output logic [15:0] x_o,
  output logic [15:0] y_o,
  output vec3         dir_o,
  output logic        last_o
);

  localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

  logic [15:0] x_q, x_d, y_q, y_d;
  vec3         col_q, col_d, row_q, row_d, dx_q, dx_d, dy_q, dy_d;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    col_d = col_q;
    row_d = row_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    if (load_i) begin
      x_d   = '0;
      y_d   = '0;
      col_d = base_i;
      row_d = base_i;
      dx_d  = dx_i;
      dy_d  = dy_i;
    end else if (advance_i) begin
      if (x_q == X_LAST) begin
        // Row restarts from the row accumulator, so column drift never carries over.
        x_d   = '0;
        y_d   = y_q + 16'd1;
        row_d = vec3_add(row_q, dy_q);
        col_d = row_d;
      end else begin
        x_d   = x_q + 16'd1;
        col_d = vec3_add(col_q, dx_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      col_q <= '0;
      row_q <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      col_q <= col_d;
      row_q <= row_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign dir_o  = col_q;
  assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule
`default_nettype wire

// File: rtl/ray_scheduler.sv
`default_nettype none
// ============================================================================
// ray_scheduler : issues raster pixels to ray marcher units, retires in order
// Rev 1.0
// ============================================================================
module ray_scheduler
  import vector_pkg::*;
#(
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 240,
  parameter int NUM_UNITS = 2,
  parameter int TIMEOUT   = 1024,
  parameter fp  MAX_DIST  = MAX_DIST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  vec3                  cam_origin,
  input  vec3                  dir_base,
  input  vec3                  dir_dx,
  input  vec3                  dir_dy,
  output logic [NUM_UNITS-1:0] unit_start,
  output vec3                  unit_origin,
  output vec3 [NUM_UNITS-1:0]  unit_dir,
  input  logic [NUM_UNITS-1:0] unit_done,
  input  fp [NUM_UNITS-1:0]    unit_dist,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          res_x,
  output logic [15:0]          res_y,
  output fp                    res_dist,
  output logic                 res_hit,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int              PTR_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_UNITS - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  sched_state_t                         state_q;
  logic [PTR_W-1:0]                     issue_ptr_q, retire_ptr_q;
  logic [NUM_UNITS-1:0]                 unit_busy_q, unit_start_q;
  vec3                                  origin_q;
  vec3 [NUM_UNITS-1:0]                  unit_dir_q;
  logic [NUM_UNITS-1:0][15:0]           unit_x_q, unit_y_q;
  logic [NUM_UNITS-1:0][TMO_W-1:0]      tmo_q;
  logic                                 res_valid_q, res_hit_q, frame_done_q;
  logic [15:0]                          res_x_q, res_y_q;
  fp                                    res_dist_q;

  logic        gen_load, gen_last;
  logic [15:0] gen_x, gen_y;
  vec3         gen_dir;
  logic        rp_done, rp_tmo, retire_fire, issue_fire, drain_done;

  ray_dir_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_dir_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (gen_load),
    .base_i   (dir_base),
    .dx_i     (dir_dx),
    .dy_i     (dir_dy),
    .advance_i(issue_fire),
    .x_o      (gen_x),
    .y_o      (gen_y),
    .dir_o    (gen_dir),
    .last_o   (gen_last)
  );

  // A unit's done level is stale while its start pulse is still on the wire.
  assign rp_done     = unit_done[retire_ptr_q];
  assign rp_tmo      = (tmo_q[retire_ptr_q] == TMO_MAX);
  assign retire_fire = unit_busy_q[retire_ptr_q] && !unit_start_q[retire_ptr_q] &&
                       (rp_done || rp_tmo) && (!res_valid_q || res_ready);
  assign issue_fire  = (state_q == ST_RUN) &&
                       (!unit_busy_q[issue_ptr_q] || (retire_fire && (retire_ptr_q == issue_ptr_q)));
  assign drain_done  = (unit_busy_q == '0) && !res_valid_q;
  assign gen_load    = (state_q == ST_IDLE) && frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      issue_ptr_q  <= '0;
      retire_ptr_q <= '0;
      unit_busy_q  <= '0;
      unit_start_q <= '0;
      origin_q     <= '0;
      unit_dir_q   <= '0;
      unit_x_q     <= '0;
      unit_y_q     <= '0;
      tmo_q        <= '0;
      res_valid_q  <= 1'b0;
      res_x_q      <= '0;
      res_y_q      <= '0;
      res_dist_q   <= '0;
      res_hit_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      unit_start_q <= '0;
      frame_done_q <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (unit_busy_q[u] && (tmo_q[u] != TMO_MAX)) tmo_q[u] <= tmo_q[u] + 1'b1;
      end
      if (res_valid_q && res_ready) res_valid_q <= 1'b0;

      if (retire_fire) begin
        unit_busy_q[retire_ptr_q] <= 1'b0;
        retire_ptr_q <= (retire_ptr_q == LAST_PTR) ? '0 : retire_ptr_q + 1'b1;
        res_valid_q  <= 1'b1;
        res_x_q      <= unit_x_q[retire_ptr_q];
        res_y_q      <= unit_y_q[retire_ptr_q];
        if (rp_done) begin
          res_dist_q <= unit_dist[retire_ptr_q];
          res_hit_q  <= (unit_dist[retire_ptr_q] < MAX_DIST);
        end else begin
          res_dist_q <= MAX_DIST;
          res_hit_q  <= 1'b0;
        end
      end

      // Issue after retire so a same-cycle reissue keeps the unit busy.
      if (issue_fire) begin
        unit_busy_q[issue_ptr_q]  <= 1'b1;
        unit_start_q[issue_ptr_q] <= 1'b1;
        unit_dir_q[issue_ptr_q]   <= gen_dir;
        unit_x_q[issue_ptr_q]     <= gen_x;
        unit_y_q[issue_ptr_q]     <= gen_y;
        tmo_q[issue_ptr_q]        <= '0;
        issue_ptr_q <= (issue_ptr_q == LAST_PTR) ? '0 : issue_ptr_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q  <= ST_RUN;
            origin_q <= cam_origin;
          end
        end
        ST_RUN: begin
          if (issue_fire && gen_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_q      <= ST_FIN;
            frame_done_q <= 1'b1;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign unit_start  = unit_start_q;
  assign unit_origin = origin_q;
  assign unit_dir    = unit_dir_q;
  assign res_valid   = res_valid_q;
  assign res_x       = res_x_q;
  assign res_y       = res_y_q;
  assign res_dist    = res_dist_q;
  assign res_hit     = res_hit_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ray_scheduler.sv
`default_nettype none
// ============================================================================
// tb_ray_scheduler : directed scenarios against a small 4x2, two-unit frame
// Rev 1.0
// ============================================================================
module tb_ray_scheduler;
  import vector_pkg::*;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NU   = 2;
  localparam int TMO  = 16;
  localparam int NPIX = W * H;
  localparam fp  MAXD = 32'sh6400_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              res_ready = 1'b1;
  vec3               cam_origin, dir_base, dir_dx, dir_dy;
  logic [NU-1:0]     unit_start;
  vec3               unit_origin;
  vec3 [NU-1:0]      unit_dir;
  logic [NU-1:0]     unit_done = '0;
  fp [NU-1:0]        unit_dist = '0;
  logic              res_valid, res_hit, busy, frame_done;
  logic [15:0]       res_x, res_y;
  fp                 res_dist;

  int   delay [NU];
  int   cnt [NU];
  fp    dist_off;
  vec3  dir_log [NPIX];
  int   n_starts;
  bit   odd_tmo;

  logic [15:0] got_x [32];
  logic [15:0] got_y [32];
  fp           got_dist [32];
  logic        got_hit [32];
  int          n_res, n_done, stall_starts;
  bit          timed_out, stall_stable;
  int          n_checks = 0;
  int          n_pass = 0;

  ray_scheduler #(
    .WIDTH(W), .HEIGHT(H), .NUM_UNITS(NU), .TIMEOUT(TMO), .MAX_DIST(MAXD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .cam_origin(cam_origin), .dir_base(dir_base), .dir_dx(dir_dx), .dir_dy(dir_dy),
    .unit_start(unit_start), .unit_origin(unit_origin), .unit_dir(unit_dir),
    .unit_done(unit_done), .unit_dist(unit_dist),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_dist(res_dist), .res_hit(res_hit),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Marcher model: done rises delay[u] cycles after start; delay 0 never finishes.
  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (unit_start[u]) begin
        if (n_starts < NPIX) dir_log[n_starts] = unit_dir[u];
        n_starts     = n_starts + 1;
        cnt[u]       = delay[u];
        unit_done[u] = 1'b0;
        unit_dist[u] = unit_dir[u].x + dist_off;
      end else if (cnt[u] > 0) begin
        cnt[u] = cnt[u] - 1;
        if (cnt[u] == 0) unit_done[u] = 1'b1;
      end
    end
  end

  function automatic fp exp_dirx(input int k);
    return dir_base.x + fp'(k % W) * dir_dx.x + fp'(k / W) * dir_dy.x;
  endfunction

  function automatic fp exp_dist(input int k);
    if (odd_tmo && (k % 2 == 1)) return MAXD;
    return exp_dirx(k) + dist_off;
  endfunction

  function automatic logic exp_hit(input int k);
    if (odd_tmo && (k % 2 == 1)) return 1'b0;
    return (exp_dist(k) < MAXD);
  endfunction

  task automatic collect_frame(input int stall_at, input bit poke_drain);
    int          cyc;
    bit          stalled, poked;
    int          s0;
    logic [15:0] hx, hy;
    fp           hd;
    logic        hh;
    n_res = 0; n_done = 0; timed_out = 1'b0; stall_stable = 1'b1; stall_starts = 0;
    stalled = 1'b0; poked = 1'b0;
    for (int i = 0; i < 32; i++) begin
      got_x[i] = 16'hFFFF; got_y[i] = 16'hFFFF; got_dist[i] = '0; got_hit[i] = 1'bx;
    end
    n_starts = 0;
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    cyc = 0;
    while (n_done == 0 && cyc < 3000) begin
      if (poked) frame_start = 1'b0;
      if (!stalled && stall_at >= 0 && n_res == stall_at && res_valid) begin
        stalled = 1'b1;
        res_ready = 1'b0;
        hx = res_x; hy = res_y; hd = res_dist; hh = res_hit;
        s0 = n_starts;
        repeat (20) begin
          @(negedge clk); cyc++;
          if (res_valid !== 1'b1 || res_x !== hx || res_y !== hy || res_dist !== hd || res_hit !== hh)
            stall_stable = 1'b0;
        end
        stall_starts = n_starts - s0;
        res_ready = 1'b1;
      end
      if (res_valid && res_ready) begin
        if (n_res < 32) begin
          got_x[n_res] = res_x; got_y[n_res] = res_y;
          got_dist[n_res] = res_dist; got_hit[n_res] = res_hit;
        end
        n_res++;
      end
      if (frame_done) n_done++;
      if (poke_drain && !poked && n_res == NPIX - 1) begin
        frame_start = 1'b1;
        poked = 1'b1;
      end
      @(negedge clk); cyc++;
    end
    frame_start = 1'b0;
    timed_out = (n_done == 0);
    repeat (60) begin
      if (res_valid && res_ready) n_res++;
      if (frame_done) n_done++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (unit_start !== 2'b00 || res_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL reset_ctrl: got start=%b valid=%b busy=%b done=%b, want 0 0 0 0",
               unit_start, res_valid, busy, frame_done);
    else n_pass++;
    n_checks++;
    if (res_x !== 16'd0 || res_y !== 16'd0 || res_dist !== 32'sd0 || res_hit !== 1'b0 || unit_dir !== '0)
      $display("FAIL reset_payload: got x=%0d y=%0d dist=%h hit=%b, want all zero",
               res_x, res_y, res_dist, res_hit);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic check_results(input string tag);
    for (int k = 0; k < NPIX; k++) begin
      n_checks++;
      if (got_x[k] !== 16'(k % W) || got_y[k] !== 16'(k / W) ||
          got_dist[k] !== exp_dist(k) || got_hit[k] !== exp_hit(k))
        $display("FAIL %s_res%0d: got x=%0d y=%0d dist=%h hit=%b, want x=%0d y=%0d dist=%h hit=%b",
                 tag, k, got_x[k], got_y[k], got_dist[k], got_hit[k],
                 k % W, k / W, exp_dist(k), exp_hit(k));
      else n_pass++;
    end
    n_checks++;
    if (timed_out || n_res !== NPIX || n_done !== 1)
      $display("FAIL %s_count: got results=%0d frame_done=%0d timeout=%b, want %0d 1 0",
               tag, n_res, n_done, timed_out, NPIX);
    else n_pass++;
  endtask

  task automatic test_raster();
    delay[0] = 5; delay[1] = 5; dist_off = '0; odd_tmo = 1'b0;
    collect_frame(-1, 1'b0);
    check_results("raster");
    n_checks++;
    if (dir_log[7].x !== 32'sh0340_0000 || dir_log[7].y !== 32'sh00A0_0000 || dir_log[7].z !== 32'shFF00_0000)
      $display("FAIL raster_dir31: got %h/%h/%h, want 03400000/00a00000/ff000000",
               dir_log[7].x, dir_log[7].y, dir_log[7].z);
    else n_pass++;
    n_checks++;
    if (dir_log[4].x !== 32'sh0040_0000 || dir_log[4].y !== 32'sh00A0_0000)
      $display("FAIL raster_dir01: got %h/%h, want 00400000/00a00000", dir_log[4].x, dir_log[4].y);
    else n_pass++;
    n_checks++;
    if (unit_origin.x !== 32'sh0100_0000 || unit_origin.y !== 32'sh0200_0000 || unit_origin.z !== 32'sh0300_0000 || busy !== 1'b0)
      $display("FAIL raster_origin: got %h/%h/%h busy=%b, want 01000000/02000000/03000000 busy=0",
               unit_origin.x, unit_origin.y, unit_origin.z, busy);
    else n_pass++;
  endtask

  task automatic test_miss();
    // 99.0 offset: pixel x=0 lands at 99.25 (hit), others at >=100.25 (miss).
    delay[0] = 4; delay[1] = 6; dist_off = 32'sh6300_0000; odd_tmo = 1'b0;
    collect_frame(-1, 1'b0);
    check_results("miss");
  endtask

  task automatic test_stall();
    delay[0] = 5; delay[1] = 5; dist_off = '0; odd_tmo = 1'b0;
    collect_frame(3, 1'b0);
    check_results("stall");
    n_checks++;
    if (stall_stable !== 1'b1 || stall_starts > NU)
      $display("FAIL stall_hold: got stable=%b starts=%0d, want stable=1 starts<=%0d",
               stall_stable, stall_starts, NU);
    else n_pass++;
  endtask

  task automatic test_timeout();
    delay[0] = 5; delay[1] = 0; dist_off = '0; odd_tmo = 1'b1;
    collect_frame(-1, 1'b0);
    check_results("timeout");
    odd_tmo = 1'b0;
  endtask

  task automatic test_out_of_order();
    delay[0] = 9; delay[1] = 2; dist_off = '0; odd_tmo = 1'b0;
    collect_frame(-1, 1'b0);
    check_results("order");
  endtask

  task automatic test_drain_poke();
    delay[0] = 5; delay[1] = 5; dist_off = '0; odd_tmo = 1'b0;
    collect_frame(-1, 1'b1);
    check_results("drain");
  endtask

  task automatic test_reset_midframe();
    int stray;
    delay[0] = 5; delay[1] = 5; dist_off = '0; odd_tmo = 1'b0;
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    repeat (12) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (unit_start !== 2'b00 || res_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
        res_x !== 16'd0 || res_y !== 16'd0 || res_dist !== 32'sd0)
      $display("FAIL midreset_outputs: got start=%b valid=%b busy=%b done=%b x=%0d y=%0d dist=%h, want all zero",
               unit_start, res_valid, busy, frame_done, res_x, res_y, res_dist);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    stray = 0;
    repeat (15) begin
      @(negedge clk);
      if (res_valid || busy || unit_start != 2'b00) stray++;
    end
    n_checks++;
    if (stray !== 0) $display("FAIL midreset_abandon: got %0d active cycles, want 0", stray);
    else n_pass++;
    collect_frame(-1, 1'b0);
    check_results("restart");
  endtask

  initial begin
    cam_origin.x = 32'sh0100_0000; cam_origin.y = 32'sh0200_0000; cam_origin.z = 32'sh0300_0000;
    dir_base.x   = 32'sh0040_0000; dir_base.y   = 32'sh0020_0000; dir_base.z   = 32'shFF00_0000;
    dir_dx.x     = 32'sh0100_0000; dir_dx.y     = 32'sh0000_0000; dir_dx.z     = 32'sh0000_0000;
    dir_dy.x     = 32'sh0000_0000; dir_dy.y     = 32'sh0080_0000; dir_dy.z     = 32'sh0000_0000;
    delay[0] = 5; delay[1] = 5; cnt[0] = 0; cnt[1] = 0;
    dist_off = '0; odd_tmo = 1'b0; n_starts = 0;
    test_reset();
    test_raster();
    test_miss();
    test_stall();
    test_timeout();
    test_out_of_order();
    test_drain_poke();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ray_scheduler.md
RAY_SCHEDULER -- requirements
Module: ray_scheduler

Interface
REQ-001 Parameter WIDTH, default 320: pixels per row.
REQ-002 Parameter HEIGHT, default 240: rows per frame.
REQ-003 Parameter NUM_UNITS, default 2: ray marcher instances controlled, range 1..4.
REQ-004 Parameter TIMEOUT, default 1024: maximum cycles a unit may stay busy before forced retire.
REQ-005 Parameter MAX_DIST, default 32'h64000000: fp 100.0, the miss distance.
REQ-006 Port clk, in, 1: single clock; all logic is clocked on its rising edge.
REQ-007 Port rst_n, in, 1: asynchronous, active-low reset.
REQ-008 Port frame_start, in, 1: one-cycle pulse that starts a frame; sampled in IDLE only.
REQ-009 Port cam_origin, in, vec3: ray origin, latched at frame_start.
REQ-010 Port dir_base, dir_dx, dir_dy, in, vec3 each: direction of pixel (0,0), per-column increment and per-row increment; latched at frame_start.
REQ-011 Port unit_start, out, NUM_UNITS: one-cycle start pulse per unit.
REQ-012 Port unit_origin, out, vec3: latched cam_origin, shared by all units.
REQ-013 Port unit_dir, out, NUM_UNITS x vec3: per-unit direction, held stable from the start pulse until that unit retires.
REQ-014 Port unit_done and unit_dist, in, NUM_UNITS and NUM_UNITS x fp: completion level and distance per unit.
REQ-015 Port res_valid/res_ready, out/in, 1 each: result handshake; a transfer occurs when both are high.
REQ-016 Port res_x/res_y/res_dist/res_hit, out, 16/16/fp/1: result payload.
REQ-017 Port busy and frame_done, out, 1 each: busy is high outside IDLE; frame_done is a one-cycle pulse.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN and FIN: IDLE->RUN on frame_start; RUN->DRAIN when the last pixel issues; DRAIN->FIN when all units have retired and the last result has transferred; FIN->IDLE after one cycle, pulsing frame_done.
REQ-019 Issue: in RUN, at most one start per cycle, to unit issue_ptr, only when that unit is idle; issue_ptr then advances modulo NUM_UNITS.
REQ-020 Pixel order SHALL be raster (x fastest). Dir SHALL be computed by accumulation: col_dir += dir_dx per pixel; at row wrap (x==WIDTH-1), row_dir += dir_dy, col_dir <= new row_dir and x <= 0. fp adds wrap (no saturation).
REQ-021 Retire SHALL occur in issue order via retire_ptr; unit retire_ptr retires when busy and (unit_done high, or timeout counter == TIMEOUT), provided the result register is empty or transferring that cycle.
REQ-022 On timeout retire: res_dist=MAX_DIST and res_hit=0; otherwise res_dist=unit_dist and res_hit=(unit_dist < MAX_DIST).
REQ-023 Each unit SHALL record its pixel x/y at issue; the retired result carries them.
REQ-024 Result register: single entry; res_valid and payload SHALL hold until res_ready; a simultaneous transfer and load SHALL keep res_valid high with the new payload.
REQ-025 A unit retiring and being reissued in the same cycle SHALL be permitted (zero bubble).
REQ-026 Latency: start to result valid is at least 1 cycle after unit_done is sampled high.
REQ-027 frame_start outside IDLE SHALL be ignored.
REQ-028 Unit timeout counters SHALL reset to 0 at each issue and saturate at TIMEOUT.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE; unit_start=0, res_valid=0, busy=0, frame_done=0; pointers, counters, x and y=0; all unit busy flags cleared; payload registers=0.
REQ-030 Reset mid-frame SHALL abandon the frame with no further results; the next frame_start restarts at (0,0).

Structure
REQ-031 fp, vec3, vec3_add and the MAX_DIST default constant SHALL live in vector_pkg; the sched_state_t enum SHALL be defined in that package too.
REQ-032 One sub-module SHALL be used: ray_dir_gen, which holds the raster counters and the direction accumulators, with an advance input and x, y, dir and last outputs.

Verification
REQ-033 WIDTH=4, HEIGHT=2, NUM_UNITS=2, dir_dx=1.0, dir_dy=0.5, model done 5 cycles after start -> 8 results in raster order; pixel (3,1) dir.x = base+3.0 and dir.y = base+0.5; one frame_done pulse.
REQ-034 res_ready held low 20 cycles mid-frame -> payload stable, no result lost or duplicated; units stall with at most 2 outstanding.
REQ-035 Unit 1 never asserts done, TIMEOUT=16 -> that pixel retires at 16 cycles with res_dist=32'h64000000 and res_hit=0; the frame completes.
REQ-036 Unit 1 finishes before unit 0 -> results still emitted in issue order.
REQ-037 rst_n pulsed low during RUN -> outputs are reset values within the same cycle; a new frame_start produces pixel (0,0) first.
REQ-038 frame_start pulsed during DRAIN -> ignored; exactly WIDTH*HEIGHT results are produced.
